// File: rtl/banked_register_file_pkg.sv
// Shared micro-op encodings, flag types and write-enable decode helpers for the register file.
package banked_register_file_pkg;

    localparam int unsigned UOP_W   = 5;
    localparam int unsigned FLAGS_W = 4;

    typedef logic [FLAGS_W-1:0] flags_t;

    localparam logic [UOP_W-1:0] NOP = 5'd0;
    localparam logic [UOP_W-1:0] ADD = 5'd1;
    localparam logic [UOP_W-1:0] SUB = 5'd2;
    localparam logic [UOP_W-1:0] CMP = 5'd3;
    localparam logic [UOP_W-1:0] LDR = 5'd4;
    localparam logic [UOP_W-1:0] STR = 5'd5;
    localparam logic [UOP_W-1:0] MOV = 5'd6;

    // Micro-ops that retire a value into the destination register.
    function automatic logic uop_writes_reg(input logic [UOP_W-1:0] u);
        return !((u == NOP) || (u == CMP) || (u == STR));
    endfunction

    // Micro-ops allowed to commit NZCV when set_flags is requested.
    function automatic logic uop_may_set_flags(input logic [UOP_W-1:0] u);
        return !((u == NOP) || (u == STR));
    endfunction

endpackage

// File: rtl/banked_register_file_reg_scoreboard.sv
// Per-register pending-write scoreboard: issue sets, retirement clears, lookup per read port.
module reg_scoreboard
    import banked_register_file_pkg::*;
#(
    parameter int unsigned NUM_REGS = 15,
    parameter int unsigned NUM_READ = 2,
    parameter int unsigned SEL_W    = $clog2(NUM_REGS)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      set_en_i,
    input  logic [SEL_W-1:0]          set_sel_i,
    input  logic                      clr_en_i,
    input  logic [SEL_W-1:0]          clr_sel_i,
    input  logic [NUM_READ*SEL_W-1:0] rd_sel_i,
    output logic [NUM_READ-1:0]       rd_pending_c_o
);

    localparam logic [SEL_W:0] REG_LIMIT = (SEL_W+1)'(NUM_REGS);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    // Set is applied after clear so a new producer supersedes the retiring one.
    always_comb begin
        pending_d = pending_q;
        if (clr_en_i) begin
            pending_d[clr_sel_i] = 1'b0;
        end
        if (set_en_i) begin
            pending_d[set_sel_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_comb begin
        rd_pending_c_o = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            if ({1'b0, rd_sel_i[i*SEL_W +: SEL_W]} < REG_LIMIT) begin
                rd_pending_c_o[i] = pending_q[rd_sel_i[i*SEL_W +: SEL_W]];
            end
        end
    end

endmodule

// File: rtl/banked_register_file.sv
// CPU register file: multi-port registered reads with write-through bypass, NZCV flags,
// and a pending-write scoreboard for hazard detection.
module banked_register_file
    import banked_register_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 15,
    parameter int unsigned NUM_READ   = 2,
    parameter int unsigned SEL_W      = $clog2(NUM_REGS)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           not_enable,
    input  logic [UOP_W-1:0]               uop,
    input  logic [SEL_W-1:0]               wr_sel,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic [FLAGS_W-1:0]             in_flags,
    input  logic                           set_flags,
    input  logic [NUM_READ*SEL_W-1:0]      rd_sel,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
    output logic [FLAGS_W-1:0]             out_flags,
    input  logic                           issue_valid,
    input  logic [SEL_W-1:0]               issue_sel,
    output logic [NUM_READ-1:0]            rd_pending
);

    localparam logic [SEL_W:0] REG_LIMIT = (SEL_W+1)'(NUM_REGS);

    logic [DATA_WIDTH-1:0]          regs_q [NUM_REGS];
    flags_t                         flags_q;
    flags_t                         out_flags_q;
    logic [NUM_READ*DATA_WIDTH-1:0] rd_data_q;
    logic [NUM_READ*DATA_WIDTH-1:0] rd_data_d;
    logic                           reg_we_c;
    logic                           flag_we_c;
    logic                           issue_en_c;

    always_comb begin
        reg_we_c   = !not_enable && uop_writes_reg(uop) && ({1'b0, wr_sel} < REG_LIMIT);
        flag_we_c  = !not_enable && set_flags && uop_may_set_flags(uop);
        issue_en_c = !not_enable && issue_valid && ({1'b0, issue_sel} < REG_LIMIT);
    end

    // Read mux with write-through bypass; out-of-range selects read as zero.
    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            if ({1'b0, rd_sel[i*SEL_W +: SEL_W]} < REG_LIMIT) begin
                if (reg_we_c && (wr_sel == rd_sel[i*SEL_W +: SEL_W])) begin
                    rd_data_d[i*DATA_WIDTH +: DATA_WIDTH] = wr_data;
                end else begin
                    rd_data_d[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[rd_sel[i*SEL_W +: SEL_W]];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < int'(NUM_REGS); r++) begin
                regs_q[r] <= '0;
            end
            flags_q     <= '0;
            rd_data_q   <= '0;
            out_flags_q <= '0;
        end else begin
            if (reg_we_c) begin
                regs_q[wr_sel] <= wr_data;
            end
            if (flag_we_c) begin
                flags_q <= in_flags;
            end
            rd_data_q   <= rd_data_d;
            out_flags_q <= flag_we_c ? in_flags : flags_q;
        end
    end

    assign rd_data   = rd_data_q;
    assign out_flags = out_flags_q;

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_READ (NUM_READ),
        .SEL_W    (SEL_W)
    ) u_scoreboard (
        .clk_i          (clock),
        .rst_i          (reset),
        .set_en_i       (issue_en_c),
        .set_sel_i      (issue_sel),
        .clr_en_i       (reg_we_c),
        .clr_sel_i      (wr_sel),
        .rd_sel_i       (rd_sel),
        .rd_pending_c_o (rd_pending)
    );

endmodule

// File: tb/tb_banked_register_file.sv
// Self-checking bench for banked_register_file: directed scenarios plus randomized traffic
// against an array-based reference model.
module tb_banked_register_file;
    import banked_register_file_pkg::*;

    localparam int DW  = 32;
    localparam int NR  = 15;
    localparam int NRD = 2;
    localparam int SW  = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic            not_enable;
    logic [4:0]      uop;
    logic [SW-1:0]   wr_sel;
    logic [DW-1:0]   wr_data;
    logic [3:0]      in_flags;
    logic            set_flags;
    logic [NRD*SW-1:0] rd_sel;
    logic [NRD*DW-1:0] rd_data;
    logic [3:0]      out_flags;
    logic            issue_valid;
    logic [SW-1:0]   issue_sel;
    logic [NRD-1:0]  rd_pending;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [DW-1:0] m_regs [NR];
    logic          m_pend [NR];
    logic [3:0]    m_flags;
    logic [3:0]    m_oflags;
    logic [DW-1:0] m_rd   [NRD];

    banked_register_file dut (
        .clock       (clock),
        .reset       (reset),
        .not_enable  (not_enable),
        .uop         (uop),
        .wr_sel      (wr_sel),
        .wr_data     (wr_data),
        .in_flags    (in_flags),
        .set_flags   (set_flags),
        .rd_sel      (rd_sel),
        .rd_data     (rd_data),
        .out_flags   (out_flags),
        .issue_valid (issue_valid),
        .issue_sel   (issue_sel),
        .rd_pending  (rd_pending)
    );

    always #5 clock = ~clock;

    // Next architectural state; reads observe the post-write register contents.
    task automatic model_step();
        bit writes;
        bit fl;
        int s;
        if (reset) begin
            for (int r = 0; r < NR; r++) begin
                m_regs[r] = '0;
                m_pend[r] = 1'b0;
            end
            m_flags  = '0;
            m_oflags = '0;
            for (int i = 0; i < NRD; i++) m_rd[i] = '0;
        end else begin
            writes = !not_enable && !(uop inside {NOP, CMP, STR}) && (int'(wr_sel) < NR);
            fl     = !not_enable && set_flags && !(uop inside {NOP, STR});
            if (writes) begin
                m_regs[wr_sel] = wr_data;
                m_pend[wr_sel] = 1'b0;
            end
            if (fl) m_flags = in_flags;
            if (!not_enable && issue_valid && (int'(issue_sel) < NR)) m_pend[issue_sel] = 1'b1;
            for (int i = 0; i < NRD; i++) begin
                s = int'(rd_sel[i*SW +: SW]);
                m_rd[i] = (s < NR) ? m_regs[s] : '0;
            end
            m_oflags = m_flags;
        end
    endtask

    function automatic logic exp_pend(input int port);
        int s;
        s = int'(rd_sel[port*SW +: SW]);
        return (s < NR) ? m_pend[s] : 1'b0;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        reset       = 1'b0;
        not_enable  = 1'b0;
        uop         = NOP;
        wr_sel      = '0;
        wr_data     = '0;
        in_flags    = '0;
        set_flags   = 1'b0;
        rd_sel      = '0;
        issue_valid = 1'b0;
        issue_sel   = '0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int r = 0; r < NR; r++) begin
            rd_sel[0 +: SW]  = SW'(r);
            rd_sel[SW +: SW] = SW'(r);
            tick();
            checks++;
            if (rd_data !== '0) begin
                failures++;
                $display("FAIL reset_rd_data r%0d got=%h exp=0", r, rd_data);
            end
            checks++;
            if (out_flags !== 4'h0 || rd_pending !== 2'b00) begin
                failures++;
                $display("FAIL reset_flags_pend r%0d got flags=%h pend=%b exp 0/00", r, out_flags, rd_pending);
            end
        end
    endtask

    task automatic test_bypass();
        idle();
        uop = ADD; wr_sel = 4'd3; wr_data = 32'hDEADBEEF; rd_sel[0 +: SW] = 4'd3;
        tick();
        checks++;
        if (rd_data[0 +: DW] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL bypass_same_cycle got=%h exp=deadbeef", rd_data[0 +: DW]);
        end
        idle();
        rd_sel[0 +: SW] = 4'd3;
        tick();
        checks++;
        if (rd_data[0 +: DW] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL bypass_later_read got=%h exp=deadbeef", rd_data[0 +: DW]);
        end
    endtask

    task automatic test_flags();
        idle();
        uop = CMP; set_flags = 1'b1; in_flags = 4'b0110; wr_sel = 4'd5; wr_data = 32'h1;
        rd_sel[0 +: SW] = 4'd5;
        tick();
        checks++;
        if (out_flags !== 4'b0110 || rd_data[0 +: DW] !== 32'h0) begin
            failures++;
            $display("FAIL cmp_flags got flags=%b r5=%h exp 0110/0", out_flags, rd_data[0 +: DW]);
        end
        uop = STR; in_flags = 4'b1001; wr_data = 32'h2;
        tick();
        checks++;
        if (out_flags !== 4'b0110 || rd_data[0 +: DW] !== 32'h0) begin
            failures++;
            $display("FAIL str_no_effect got flags=%b r5=%h exp 0110/0", out_flags, rd_data[0 +: DW]);
        end
    endtask

    task automatic test_not_enable();
        idle();
        not_enable = 1'b1; uop = ADD; wr_sel = 4'd7; wr_data = 32'h55;
        set_flags = 1'b1; in_flags = 4'b1111;
        issue_valid = 1'b1; issue_sel = 4'd7;
        rd_sel[0 +: SW] = 4'd7; rd_sel[SW +: SW] = 4'd3;
        tick();
        checks++;
        if (rd_data[0 +: DW] !== 32'h0 || rd_data[DW +: DW] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL frozen_reads got p0=%h p1=%h exp 0/deadbeef", rd_data[0 +: DW], rd_data[DW +: DW]);
        end
        checks++;
        if (rd_pending !== 2'b00 || out_flags !== 4'b0110) begin
            failures++;
            $display("FAIL frozen_state got pend=%b flags=%b exp 00/0110", rd_pending, out_flags);
        end
        idle();
        rd_sel[0 +: SW] = 4'd7;
        tick();
        checks++;
        if (rd_data[0 +: DW] !== 32'h0 || rd_pending[0] !== 1'b0) begin
            failures++;
            $display("FAIL frozen_after got r7=%h pend=%b exp 0/0", rd_data[0 +: DW], rd_pending[0]);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        issue_valid = 1'b1; issue_sel = 4'd2; rd_sel[0 +: SW] = 4'd2;
        tick();
        checks++;
        if (rd_pending[0] !== 1'b1) begin
            failures++;
            $display("FAIL sb_issue got=%b exp=1", rd_pending[0]);
        end
        uop = ADD; wr_sel = 4'd2; wr_data = 32'h1234;
        tick();
        checks++;
        if (rd_pending[0] !== 1'b1 || rd_data[0 +: DW] !== 32'h1234) begin
            failures++;
            $display("FAIL sb_set_wins got pend=%b data=%h exp 1/1234", rd_pending[0], rd_data[0 +: DW]);
        end
        issue_valid = 1'b0; wr_data = 32'h5678;
        tick();
        checks++;
        if (rd_pending[0] !== 1'b0) begin
            failures++;
            $display("FAIL sb_clear got=%b exp=0", rd_pending[0]);
        end
    endtask

    task automatic test_out_of_range();
        idle();
        uop = ADD; wr_sel = 4'd15; wr_data = 32'hCAFEF00D;
        issue_valid = 1'b1; issue_sel = 4'd15;
        rd_sel[0 +: SW] = 4'd15; rd_sel[SW +: SW] = 4'd3;
        tick();
        checks++;
        if (rd_data[0 +: DW] !== 32'h0 || rd_pending[0] !== 1'b0 || rd_data[DW +: DW] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL oor got p0=%h pend=%b p1=%h exp 0/0/deadbeef",
                     rd_data[0 +: DW], rd_pending[0], rd_data[DW +: DW]);
        end
        idle();
        for (int r = 0; r < NR; r += 2) begin
            rd_sel[0 +: SW]  = SW'(r);
            rd_sel[SW +: SW] = SW'(r + 1);
            tick();
            for (int p = 0; p < NRD; p++) begin
                checks++;
                if (rd_data[p*DW +: DW] !== m_rd[p]) begin
                    failures++;
                    $display("FAIL oor_scan r%0d got=%h exp=%h", r + p, rd_data[p*DW +: DW], m_rd[p]);
                end
            end
        end
    endtask

    task automatic test_reset_pending();
        idle();
        issue_valid = 1'b1; issue_sel = 4'd9; rd_sel[0 +: SW] = 4'd9;
        tick();
        checks++;
        if (rd_pending[0] !== 1'b1) begin
            failures++;
            $display("FAIL rstp_pre got=%b exp=1", rd_pending[0]);
        end
        reset = 1'b1; uop = ADD; wr_sel = 4'd9; wr_data = 32'h77; set_flags = 1'b1; in_flags = 4'hF;
        tick();
        checks++;
        if (rd_pending[0] !== 1'b0 || rd_data !== '0 || out_flags !== 4'h0) begin
            failures++;
            $display("FAIL rstp_cleared got pend=%b data=%h flags=%h exp 0/0/0", rd_pending[0], rd_data, out_flags);
        end
        idle();
        rd_sel[0 +: SW] = 4'd9;
        tick();
        checks++;
        if (rd_pending[0] !== 1'b0 || rd_data[0 +: DW] !== 32'h0) begin
            failures++;
            $display("FAIL rstp_post got pend=%b r9=%h exp 0/0", rd_pending[0], rd_data[0 +: DW]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset       = ($urandom_range(0, 49) == 0);
            not_enable  = ($urandom_range(0, 7) == 0);
            uop         = 5'($urandom_range(0, 7));
            wr_sel      = 4'($urandom_range(0, 15));
            wr_data     = $urandom;
            in_flags    = 4'($urandom_range(0, 15));
            set_flags   = 1'($urandom_range(0, 1));
            rd_sel      = 8'($urandom_range(0, 255));
            issue_valid = 1'($urandom_range(0, 1));
            issue_sel   = 4'($urandom_range(0, 15));
            tick();
            for (int p = 0; p < NRD; p++) begin
                checks++;
                if (rd_data[p*DW +: DW] !== m_rd[p]) begin
                    failures++;
                    $display("FAIL rand_rd n=%0d p%0d got=%h exp=%h", n, p, rd_data[p*DW +: DW], m_rd[p]);
                end
                checks++;
                if (rd_pending[p] !== exp_pend(p)) begin
                    failures++;
                    $display("FAIL rand_pend n=%0d p%0d got=%b exp=%b", n, p, rd_pending[p], exp_pend(p));
                end
            end
            checks++;
            if (out_flags !== m_oflags) begin
                failures++;
                $display("FAIL rand_flags n=%0d got=%h exp=%h", n, out_flags, m_oflags);
            end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_bypass();
        test_flags();
        test_not_enable();
        test_scoreboard();
        test_out_of_range();
        test_reset_pending();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
